// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: tracks in-flight writers per stage and resolves
// each ID operand to a stall, a forward from the youngest producer, or the register file.
module hazard_scoreboard #(
    parameter int NSRC     = 2,
    parameter int DEPTH    = 3,
    parameter int REGW     = 5,
    parameter int ALU_RDY  = 1,
    parameter int LOAD_RDY = 2,
    localparam int SELW    = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [NSRC*REGW-1:0]   id_rs,
    input  logic [NSRC-1:0]        id_rs_used,
    input  logic [REGW-1:0]        id_rd,
    input  logic                   id_we,
    input  logic                   id_is_load,
    input  logic                   flush,
    output logic                   stall,
    output logic [NSRC*SELW-1:0]   fwd_sel,
    output logic [31:0]            stall_cnt,
    output logic [31:0]            fwd_cnt
);

    logic [DEPTH:1]  e_valid;
    logic [DEPTH:1]  e_we;
    logic [DEPTH:1]  e_load;
    logic [REGW-1:0] e_rd [1:DEPTH];

    logic [31:0]     fwd_num;
    logic            blocked;
    logic [32:0]     stall_sum;
    logic [32:0]     fwd_sum;

    // Walk stages oldest-first so the youngest matching producer wins.
    always_comb begin
        logic            hit;
        logic            hit_rdy;
        logic [SELW-1:0] hit_k;
        blocked = 1'b0;
        fwd_sel = '0;
        fwd_num = '0;
        for (int i = 0; i < NSRC; i++) begin
            hit     = 1'b0;
            hit_rdy = 1'b0;
            hit_k   = '0;
            for (int k = DEPTH; k >= 1; k--) begin
                if (e_valid[k] && e_we[k] && id_rs_used[i] &&
                    e_rd[k] == id_rs[i*REGW +: REGW] && e_rd[k] != '0) begin
                    hit     = 1'b1;
                    hit_k   = SELW'(k);
                    hit_rdy = e_load[k] ? (k >= LOAD_RDY) : (k >= ALU_RDY);
                end
            end
            if (hit && !hit_rdy)
                blocked = 1'b1;
            if (hit && hit_rdy) begin
                fwd_sel[i*SELW +: SELW] = hit_k;
                fwd_num                 = fwd_num + 32'd1;
            end
        end
        stall = id_valid && !flush && blocked;
    end

    assign stall_sum = {1'b0, stall_cnt} + 33'(stall);
    assign fwd_sum   = {1'b0, fwd_cnt} +
                       ((id_valid && !flush && !stall) ? {1'b0, fwd_num} : 33'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            e_valid   <= '0;
            e_we      <= '0;
            e_load    <= '0;
            for (int k = 1; k <= DEPTH; k++)
                e_rd[k] <= '0;
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            e_valid[1] <= id_valid && !stall && !flush;
            e_we[1]    <= id_we;
            e_load[1]  <= id_is_load;
            e_rd[1]    <= id_rd;
            for (int k = 2; k <= DEPTH; k++) begin
                e_valid[k] <= e_valid[k-1];
                e_we[k]    <= e_we[k-1];
                e_load[k]  <= e_load[k-1];
                e_rd[k]    <= e_rd[k-1];
            end
            stall_cnt <= stall_sum[32] ? 32'hFFFF_FFFF : stall_sum[31:0];
            fwd_cnt   <= fwd_sum[32]   ? 32'hFFFF_FFFF : fwd_sum[31:0];
        end
    end

endmodule
